// File: rtl/day11_rr_mux_4to1.sv
// day11_rr_mux_4to1
//   Four-channel round-robin collector. Picks one valid source beat per cycle
//   with a rotating-priority arbiter. The picked beat goes into a single
//   registered valid/ready output stage, tagged with its source channel index.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel valid, bit i = channel i
//   in_data    channel i data in bits [i*WIDTH +: WIDTH]
//   in_ready   per-channel ready, one-hot or zero
//   out_valid  output register holds a beat
//   out_data   data of held beat
//   out_sel    source channel index of held beat
//   out_ready  downstream accepts beat when high with out_valid
module day11_rr_mux_4to1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  // Channel with highest priority on the next arbitration.
  logic [1:0]       ptr_q, ptr_d;

  logic             load_en;
  logic             grant_valid;
  logic [1:0]       grant;
  logic [WIDTH-1:0] grant_data;

  // The register can take a new beat when it is empty or drains this cycle.
  // This allows a drain and a load in the same cycle.
  assign load_en = !out_valid_q || out_ready;

  // Rotating-priority search starting at ptr_q. The first requester wins.
  always_comb begin
    logic [1:0] idx;
    idx         = ptr_q;
    grant_valid = 1'b0;
    grant       = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_valid && in_valid[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  assign grant_data = in_data[32'(grant)*WIDTH +: WIDTH];

  // Gate with rst_n so that no source sees ready while the block is in reset.
  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && load_en && grant_valid) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (grant_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_sel_d   = grant;
        ptr_d       = grant + 2'd1;
      end else begin
        // Data and sel keep their old values. Only valid drops.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      ptr_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_day11_rr_mux_4to1.sv
// tb_day11_rr_mux_4to1
//   Directed vector table for day11_rr_mux_4to1, plus hand sequences for
//   mid-stream reset and full contention after reset.
//   Inputs change 1 time unit after posedge. Outputs are checked at negedge.
module tb_day11_rr_mux_4to1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int npass;
  int ntotal;

  day11_rr_mux_4to1 #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  ir;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] iv, input logic [31:0] d, input logic ordy,
                              input logic [3:0] ir, input logic ov, input logic [7:0] od,
                              input logic [1:0] os);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.os = os;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  localparam logic [31:0] DALL = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
  localparam logic [31:0] DA5  = {8'hD3, 8'hA5, 8'hB1, 8'hA0};

  initial begin
    npass = 0;
    ntotal = 0;
    rst_n = 1'b0;
    in_valid = 4'b0000;
    in_data = DALL;
    out_ready = 1'b1;

    // Each row gives the inputs for one cycle and the state expected in that cycle.
    // The state is the combinational in_ready and the registered output seen before the edge.
    // Single channel 2 from reset, sustained
    add(4'b0100, DA5, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0);
    add(4'b0100, DA5, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    add(4'b0100, DA5, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    // Drain to idle; ptr stays 3
    add(4'b0000, DA5, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd2);
    add(4'b0000, DA5, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2);
    // All request: channel 3 (ptr) first, then wrap to 0, 1
    add(4'b1111, DALL, 1'b1, 4'b1000, 1'b0, 8'hA5, 2'd2);
    add(4'b1111, DALL, 1'b1, 4'b0001, 1'b1, 8'hD3, 2'd3);
    add(4'b1111, DALL, 1'b1, 4'b0010, 1'b1, 8'hA0, 2'd0);
    // Backpressure 3 cycles holding channel 1, then same-cycle load of channel 2
    add(4'b1111, DALL, 1'b0, 4'b0000, 1'b1, 8'hB1, 2'd1);
    add(4'b1111, DALL, 1'b0, 4'b0000, 1'b1, 8'hB1, 2'd1);
    add(4'b1111, DALL, 1'b0, 4'b0000, 1'b1, 8'hB1, 2'd1);
    add(4'b1111, DALL, 1'b1, 4'b0100, 1'b1, 8'hB1, 2'd1);
    // Channel 0 alone moves ptr to 1, then sparse 1001 skips to 3, then 0
    add(4'b0001, DALL, 1'b1, 4'b0001, 1'b1, 8'hC2, 2'd2);
    add(4'b1001, DALL, 1'b1, 4'b1000, 1'b1, 8'hA0, 2'd0);
    add(4'b1001, DALL, 1'b1, 4'b0001, 1'b1, 8'hD3, 2'd3);
    // Hold, then drain to idle
    add(4'b0000, DALL, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    add(4'b0000, DALL, 1'b1, 4'b0000, 1'b1, 8'hA0, 2'd0);
    add(4'b0000, DALL, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0);

    // Reset held with a request pending: in_ready must stay low
    in_valid = 4'b1111;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    in_valid = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      check($sformatf("v%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].os));
      @(posedge clk);
      #1;
    end

    // ptr is 1 after the table, so channel 1 is loaded. Then reset is asserted mid-cycle.
    in_valid  = 4'b1111;
    in_data   = DALL;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'h1);
    check("pre_rst_out_sel", 32'(out_sel), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'h0);
    check("async_rst_out_data", 32'(out_data), 32'h0);
    check("async_rst_out_sel", 32'(out_sel), 32'h0);
    check("async_rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full contention from reset: 0,1,2,3,0,1 with no bubbles
    @(negedge clk);
    check("cont_first_in_ready", 32'(in_ready), 32'h1);
    check("cont_first_out_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("cont%0d_out_valid", k), 32'(out_valid), 32'h1);
      check($sformatf("cont%0d_out_sel", k), 32'(out_sel), 32'(k % 4));
      check($sformatf("cont%0d_out_data", k), 32'(out_data), 32'(8'hA0 + 8'h11 * (k % 4)));
      check($sformatf("cont%0d_in_ready", k), 32'(in_ready), 32'(4'b0001 << ((k + 1) % 4)));
    end

    in_valid = 4'b0000;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  // Watchdog timer that stops the run if the test does not finish in time.
  initial begin
    #20000;
    $display("FAIL watchdog: timeout got %0d/%0d checks", npass, ntotal);
    $fatal(1, "timeout");
  end

endmodule
